keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad (Basys3 Pmod) by driving one column low at a time and reading the rows.

---
 rtl/keypad_pkg.sv | 45 ++++
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_col_scan.sv | 53 +++++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int CODE_W   = 4;
    localparam int CNT_W    = 4;   // holds debounce counts up to 15

    // Result of one full scan of the matrix.
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } key_class_t;

    // Report FSM: ARMED waits for a stable press, HELD waits for a stable release.
    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_HELD  = 1'b1
    } state_t;

    // Number of closed keys in a snapshot.
    function automatic logic [4:0] popcount16(input logic [NUM_KEYS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest closed key; only meaningful when exactly one is set.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-side and report-side signals of the keypad scanner.
// Handshake: key_valid is a one-cycle strobe with no ready; key_code is
// valid in the strobe cycle and holds until the next strobe. The consumer
// must sample key_code whenever key_valid is high; there is no back-pressure.
interface keypad_scanner_if import keypad_pkg::*; ();

    logic [NUM_ROWS-1:0] row_in;     // active-low rows from the pads
    logic [NUM_COLS-1:0] col_out;    // active-low column drive
    logic [CODE_W-1:0]   key_code;   // row*4 + col of last accepted key
    logic                key_valid;  // one-cycle strobe on accept
    logic                key_held;   // accepted key not yet released

    // master: the scanner itself
    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    // slave: board pins plus the consumer of key reports
    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_col_scan.sv
// Column sequencer: dwells SCAN_DIV cycles on each column, drives it low,
// and flags the last dwell cycle (row sample point) and the end of a scan.
module keypad_col_scan import keypad_pkg::*; #(
    parameter int SCAN_DIV = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [1:0]          col_idx_o,
    output logic [NUM_COLS-1:0] col_out_o,
    output logic                sample_o,
    output logic                scan_end_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_COLS-1:0] col_out_q, col_out_d;
    logic                sample;

    // Rows have settled by the last dwell cycle of the driven column.
    assign sample = (dwell_q == DW'(SCAN_DIV - 1));

    // Next dwell/column; the 2-bit column index wraps mod 4 by design.
    always_comb begin
        dwell_d   = dwell_q + DW'(1);
        col_d     = col_q;
        if (sample) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
        end
        col_out_d = ~(4'b0001 << col_d);
    end

    // Counter and column-drive registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell_q   <= '0;
            col_q     <= '0;
            col_out_q <= 4'b1110;
        end else begin
            dwell_q   <= dwell_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
        end
    end

    assign col_idx_o  = col_q;
    assign col_out_o  = col_out_q;
    assign sample_o   = sample;
    assign scan_end_o = sample && (col_q == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: builds a per-scan snapshot of closed keys, classifies
// it, debounces across whole scans and reports each press exactly once.
module keypad_scanner import keypad_pkg::*; #(
    parameter int SCAN_DIV       = 1,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp,
    output state_t            dbg_state_o
);

    logic [1:0]          col_idx;
    logic                sample;
    logic                scan_end;

    logic [NUM_KEYS-1:0] snap_q, snap_d, snap_now;
    logic [4:0]          pop_now;
    key_class_t          cls_now;
    logic [CODE_W-1:0]   code_now;

    key_class_t          prev_cls_q, prev_cls_d;
    logic [CODE_W-1:0]   prev_code_q, prev_code_d;
    logic [CNT_W-1:0]    stable_cnt_q, stable_cnt_d;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_idx_o  (col_idx),
        .col_out_o  (kp.col_out),
        .sample_o   (sample),
        .scan_end_o (scan_end)
    );

    // Snapshot including the column being sampled this cycle; cleared after scan end.
    always_comb begin
        snap_now = snap_q;
        if (sample) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                snap_now[r * NUM_COLS + int'(col_idx)] = ~kp.row_in[r];
            end
        end
        snap_d = scan_end ? '0 : snap_now;
    end

    // Classify the completed snapshot; only consumed on scan_end.
    always_comb begin
        pop_now  = popcount16(snap_now);
        cls_now  = CLS_NONE;
        code_now = '0;
        if (pop_now == 5'd1) begin
            cls_now  = CLS_SINGLE;
            code_now = lowest_set(snap_now);
        end else if (pop_now > 5'd1) begin
            cls_now  = CLS_MULTI;
        end
    end

    // Debounce: count consecutive scans with identical class and code.
    always_comb begin
        prev_cls_d   = prev_cls_q;
        prev_code_d  = prev_code_q;
        stable_cnt_d = stable_cnt_q;
        if (scan_end) begin
            prev_cls_d  = cls_now;
            prev_code_d = code_now;
            if ((cls_now == prev_cls_q) && (code_now == prev_code_q)) begin
                if (stable_cnt_q != CNT_W'(DEBOUNCE_SCANS)) begin
                    stable_cnt_d = stable_cnt_q + CNT_W'(1);
                end
            end else begin
                stable_cnt_d = CNT_W'(1);
            end
        end
    end

    // Report FSM next state and outputs; acts only at scan end.
    always_comb begin
        state_d     = state_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (scan_end) begin
            case (state_q)
                ST_ARMED: begin
                    if ((cls_now == CLS_SINGLE) &&
                        (stable_cnt_d == CNT_W'(DEBOUNCE_SCANS))) begin
                        key_code_d  = code_now;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        state_d     = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if ((cls_now == CLS_NONE) &&
                        (stable_cnt_d == CNT_W'(DEBOUNCE_SCANS))) begin
                        key_held_d = 1'b0;
                        state_d    = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end
    end

    // State, debounce and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_q       <= '0;
            prev_cls_q   <= CLS_NONE;
            prev_code_q  <= '0;
            stable_cnt_q <= '0;
            state_q      <= ST_ARMED;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            prev_cls_q   <= prev_cls_d;
            prev_code_q  <= prev_code_d;
            stable_cnt_q <= stable_cnt_d;
            state_q      <= state_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from col_out and a
// pressed-key mask; a per-scan behavioural model predicts every output.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 1;
    localparam int DB       = 4;
    localparam int SCAN_LEN = 4 * SCAN_DIV;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp_if ();
    state_t dbg_state;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .kp          (kp_if),
        .dbg_state_o (dbg_state)
    );

    // ---------------- keypad model ----------------
    logic [15:0] pressed = '0;
    logic [3:0]  rows;
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && !kp_if.col_out[c]) rows[r] = 1'b0;
            end
        end
    end
    assign kp_if.row_in = rows;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works per scan: each cycle is a position in the scan (column, dwell);
    // the pressed mask seen at a column's last dwell cycle fills that column.
    int          m_t;          // posedges since reset release
    logic [15:0] m_seen;       // keys seen so far in the current scan
    int          m_prev_kind;  // 0 none, 1 single, 2 multi
    int          m_prev_key;
    int          m_agree;      // consecutive agreeing scans, capped at DB
    bit          m_held;
    logic [3:0]  m_key;
    bit          m_strobe;

    task automatic model_reset();
        m_t = 0; m_seen = '0; m_prev_kind = 0; m_prev_key = 0;
        m_agree = 0; m_held = 0; m_key = '0; m_strobe = 0;
    endtask

    task automatic model_edge();
        int col, kind, key, n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_strobe = 0;
        col = (m_t / SCAN_DIV) % 4;
        if ((m_t % SCAN_DIV) == SCAN_DIV - 1) begin
            for (int r = 0; r < 4; r++) m_seen[r * 4 + col] = pressed[r * 4 + col];
            if (col == 3) begin
                n = 0; key = 0;
                for (int k = 0; k < 16; k++) if (m_seen[k]) begin n++; key = k; end
                kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
                if (kind != 1) key = 0;
                if (kind == m_prev_kind && key == m_prev_key) m_agree = (m_agree < DB) ? m_agree + 1 : DB;
                else m_agree = 1;
                m_prev_kind = kind; m_prev_key = key;
                if (!m_held && kind == 1 && m_agree == DB) begin
                    m_key = 4'(key); m_strobe = 1; m_held = 1;
                end else if (m_held && kind == 0 && m_agree == DB) begin
                    m_held = 0;
                end
                m_seen = '0;
            end
        end
        m_t++;
    endtask

    // ---------------- driver ----------------
    int         n_strobe = 0;
    logic [3:0] last_code = '0;

    task automatic step();
        logic [3:0] exp_col;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        exp_col = ~(4'b0001 << ((m_t / SCAN_DIV) % 4));
        check("col_out",   16'(kp_if.col_out),   16'(exp_col));
        check("key_valid", 16'(kp_if.key_valid), 16'(m_strobe));
        check("key_code",  16'(kp_if.key_code),  16'(m_key));
        check("key_held",  16'(kp_if.key_held),  16'(m_held));
        check("state",     16'(dbg_state),       m_held ? 16'(ST_HELD) : 16'(ST_ARMED));
        if (kp_if.key_valid) begin
            n_strobe++;
            last_code = kp_if.key_code;
        end
    endtask

    task automatic run_scans(input int n);
        repeat (n * SCAN_LEN) step();
    endtask

    task automatic align_scan();
        while ((m_t % SCAN_LEN) != 0) step();
    endtask

    task automatic run_until_strobe(input int max_steps, output int n_steps);
        n_steps = 0;
        do begin
            step();
            n_steps++;
        end while (!kp_if.key_valid && n_steps < max_steps);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, s0, dur, kind;
        logic [3:0] seq [4];
        model_reset();

        // 1: reset values, then column walk
        rst_n = 1'b0; pressed = '0;
        repeat (3) step();
        check("rst_col_out", 16'(kp_if.col_out), 16'h000E);
        check("rst_held", 16'(kp_if.key_held), 16'h0);
        rst_n = 1'b1;
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            step();
            check("col_walk", 16'(kp_if.col_out), 16'(seq[i]));
        end
        run_scans(4);

        // 2: single press, latency, one strobe while held, release
        align_scan();
        pressed = 16'(1) << 9;
        s0 = n_strobe;
        run_until_strobe(100, lat);
        check("press_latency", 16'(lat), 16'(4 * SCAN_LEN));
        check("press_code", 16'(last_code), 16'd9);
        run_scans(20);
        check("hold_one_strobe", 16'(n_strobe - s0), 16'd1);
        pressed = '0;
        repeat (4 * SCAN_LEN - 1) step();
        check("held_before_release", 16'(kp_if.key_held), 16'd1);
        step();
        check("held_after_release", 16'(kp_if.key_held), 16'd0);
        run_scans(1);

        // 3: bounce on alternate scans
        s0 = n_strobe;
        for (int i = 0; i < 10; i++) begin
            pressed = (i % 2 == 0) ? (16'(1) << 5) : 16'h0;
            run_scans(1);
        end
        pressed = '0;
        check("bounce_no_strobe", 16'(n_strobe - s0), 16'd0);
        check("bounce_not_held", 16'(kp_if.key_held), 16'd0);
        run_scans(5);

        // 4: ghosting, then a single survivor
        s0 = n_strobe;
        pressed = 16'h8001;
        run_scans(8);
        check("ghost_no_strobe", 16'(n_strobe - s0), 16'd0);
        pressed = 16'h0001;
        run_scans(5);
        check("ghost_then_single", 16'(n_strobe - s0), 16'd1);
        check("ghost_code", 16'(last_code), 16'd0);
        pressed = '0;
        run_scans(5);

        // 5: re-press, then switch without release
        s0 = n_strobe;
        pressed = 16'(1) << 3;  run_scans(5);
        pressed = '0;           run_scans(4);
        pressed = 16'(1) << 3;  run_scans(5);
        check("repress_count", 16'(n_strobe - s0), 16'd2);
        check("repress_code", 16'(last_code), 16'd3);
        pressed = 16'(1) << 7;  run_scans(8);
        check("switch_no_strobe", 16'(n_strobe - s0), 16'd2);
        pressed = '0;           run_scans(5);

        // 6: reset mid-scan while held, re-report after release
        pressed = 16'(1) << 12;
        run_scans(5);
        check("pre_reset_held", 16'(kp_if.key_held), 16'd1);
        repeat (2) step();
        rst_n = 1'b0;
        repeat (2) step();
        check("mid_rst_held", 16'(kp_if.key_held), 16'd0);
        check("mid_rst_code", 16'(kp_if.key_code), 16'd0);
        rst_n = 1'b1;
        s0 = n_strobe;
        run_until_strobe(100, lat);
        check("post_reset_latency", 16'(lat), 16'(4 * SCAN_LEN));
        check("post_reset_code", 16'(last_code), 16'd12);
        run_scans(100);
        check("long_hold_one_strobe", 16'(n_strobe - s0), 16'd1);
        pressed = '0;
        run_scans(5);

        // random: unaligned pattern changes and occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       pressed = '0;
                1, 2:    pressed = 16'(1) << $urandom_range(0, 15);
                default: pressed = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            endcase
            dur = $urandom_range(1, 8 * SCAN_LEN);
            repeat (dur) step();
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) step();
                rst_n = 1'b1;
            end
        end
        pressed = '0;
        run_scans(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
